// File: rtl/shift_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_seq_pkg : shared types/constants for the shift sequencer     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Direction names are carried as packed strings so they can be compared at elaboration.
  localparam int               DIR_W     = 64;
  localparam logic [DIR_W-1:0] DIR_LEFT  = "LEFT";
  localparam logic [DIR_W-1:0] DIR_RIGHT = "RIGHT";

endpackage
`default_nettype wire

// File: rtl/shift_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_datapath : loadable WIDTH-bit logical shift register         |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module shift_datapath
  import shift_seq_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter logic [DIR_W-1:0] SHIFT_DIRECTION = DIR_LEFT,
  parameter int               SHIFT_AMOUNT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] po
);

  logic [WIDTH-1:0] shifted;

  // Anything other than RIGHT falls back to a left shift.
  generate
    if (SHIFT_DIRECTION == DIR_RIGHT) begin : g_right
      assign shifted = po >> SHIFT_AMOUNT;
    end else begin : g_left
      assign shifted = po << SHIFT_AMOUNT;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      po <= '0;
    end else if (load) begin
      po <= load_value;
    end else if (shift_en) begin
      po <= shifted;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_sequencer : handshake-driven controller for shift_datapath   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter logic [DIR_W-1:0] SHIFT_DIRECTION = DIR_LEFT,
  parameter int               SHIFT_AMOUNT    = 1,
  parameter int               MAX_STEPS       = 8,
  localparam int              STEP_W          = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STEP_W-1:0] in_steps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy
);

  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);

  state_t            state;
  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] clamped;
  logic              load;
  logic              shift_en;

  assign clamped  = (in_steps > MAX_CNT) ? MAX_CNT : in_steps;
  assign load     = (state == IDLE) && in_valid;
  assign shift_en = (state == SHIFT);

  // Status outputs are registered alongside the state so they never see input paths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt      <= clamped;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (clamped == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == STEP_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  shift_datapath #(
    .WIDTH           (WIDTH),
    .SHIFT_DIRECTION (SHIFT_DIRECTION),
    .SHIFT_AMOUNT    (SHIFT_AMOUNT)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift_en   (shift_en),
    .load_value (in_data),
    .po         (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shift_sequencer : LEFT/1 and RIGHT/2 instances vs. arithmetic   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0, busy_a;
  logic [7:0] in_data_a = 8'h00, out_data_a;
  logic [3:0] in_steps_a = 4'h0;

  logic       in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0, busy_b;
  logic [7:0] in_data_b = 8'h00, out_data_b;
  logic [3:0] in_steps_b = 4'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_sequencer #(
    .WIDTH(8), .SHIFT_DIRECTION("LEFT"), .SHIFT_AMOUNT(1), .MAX_STEPS(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_steps(in_steps_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a)
  );

  shift_sequencer #(
    .WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .SHIFT_AMOUNT(2), .MAX_STEPS(8)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_steps(in_steps_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
  );

  // Reference: total displacement = steps * amount, computed by multiply/divide by 2^k.
  function automatic logic [7:0] model_left(input logic [7:0] d, input int k);
    if (k >= 8) return 8'h00;
    return 8'((int'(d) * (2 ** k)) % 256);
  endfunction

  function automatic logic [7:0] model_right(input logic [7:0] d, input int k);
    if (k >= 8) return 8'h00;
    return 8'(int'(d) / (2 ** k));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Job on the LEFT/1 instance; hold = cycles of back-pressure in DONE with a second job offered.
  task automatic job_a(input logic [7:0] d, input logic [3:0] s, input int hold);
    int         n;
    logic [7:0] exp;
    n   = (s > 4'd8) ? 8 : int'(s);
    exp = model_left(d, n);
    chk("a_idle_ready", 8'(in_ready_a), 8'h01);
    in_valid_a  = 1'b1;
    in_data_a   = d;
    in_steps_a  = s;
    out_ready_a = 1'b0;
    tick();
    in_valid_a = 1'b0;
    in_data_a  = 8'($urandom);
    in_steps_a = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      chk("a_shift_busy", 8'(busy_a), 8'h01);
      chk("a_shift_nvalid", 8'(out_valid_a), 8'h00);
      chk("a_shift_nready", 8'(in_ready_a), 8'h00);
      tick();
    end
    chk("a_done_valid", 8'(out_valid_a), 8'h01);
    chk("a_done_data", out_data_a, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 8'($urandom);
      in_steps_a = 4'($urandom);
      tick();
      chk("a_hold_valid", 8'(out_valid_a), 8'h01);
      chk("a_hold_data", out_data_a, exp);
      chk("a_hold_nready", 8'(in_ready_a), 8'h00);
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk("a_exit_nvalid", 8'(out_valid_a), 8'h00);
    chk("a_exit_ready", 8'(in_ready_a), 8'h01);
    chk("a_exit_nbusy", 8'(busy_a), 8'h00);
  endtask

  // Job on the RIGHT/2 instance, checking latency to out_valid with a bounded wait.
  task automatic job_b(input logic [7:0] d, input logic [3:0] s);
    int n;
    int waited;
    n = (s > 4'd8) ? 8 : int'(s);
    in_valid_b = 1'b1;
    in_data_b  = d;
    in_steps_b = s;
    tick();
    in_valid_b = 1'b0;
    waited     = 0;
    while (!out_valid_b && waited < 20) begin
      tick();
      waited++;
    end
    chk("b_latency", 8'(waited), 8'(n));
    chk("b_data", out_data_b, model_right(d, 2 * n));
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    chk("b_exit_ready", 8'(in_ready_b), 8'h01);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 8'(in_ready_a), 8'h01);
    chk("rst_out_valid", 8'(out_valid_a), 8'h00);
    chk("rst_busy", 8'(busy_a), 8'h00);
    chk("rst_out_data", out_data_a, 8'h00);
    rst = 1'b1;
    tick();

    // out_ready while idle must not disturb anything
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk("idle_oready_busy", 8'(busy_a), 8'h00);

    job_a(8'h5A, 4'd3, 0);
    job_a(8'h3C, 4'd0, 0);
    job_a(8'hFF, 4'd15, 0);
    job_a(8'h81, 4'd2, 5);
    job_a(8'h96, 4'd1, 0);
    job_b(8'hF0, 4'd2);
    job_b(8'hA5, 4'd0);
    job_b(8'hFF, 4'd9);

    for (int j = 0; j < 16; j++) begin
      job_a(8'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      job_b(8'($urandom), 4'($urandom_range(0, 15)));
    end

    // Reset during the second SHIFT cycle discards the job asynchronously
    in_valid_a = 1'b1;
    in_data_a  = 8'hC3;
    in_steps_a = 4'd4;
    tick();
    in_valid_a = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 8'(in_ready_a), 8'h01);
    chk("mid_rst_out_valid", 8'(out_valid_a), 8'h00);
    chk("mid_rst_busy", 8'(busy_a), 8'h00);
    chk("mid_rst_out_data", out_data_a, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    tick();
    job_a(8'h01, 4'd1, 0);
    chk("post_rst_data", out_data_a, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
